alu_ctrl_seq: RTL and testbench

//  Issuing side of the nbit ALU interface. Accepts MIPS-style requests {ALUOp, funct, A, B} on a valid/ready handshake.

---
 rtl/alu_ctrl_seq.sv | 158 +++++++++++++++
 tb/tb_alu_ctrl_seq.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: issuing side of the nbit ALU.
// It decodes MIPS-style {ALUOp, funct} requests into the ALU's aluop/cin and drives
// registered operands into the combinational ALU. It captures result/cout/zero and
// returns them on a valid/ready channel, with one request in flight at a time.
//
// state | meaning
// IDLE  | in_ready=1, waiting for a request
// ISSUE | operands/op driven to the ALU from registers
// CAPT  | ALU outputs settled, captured into out_* at the end of the cycle
// DONE  | response held until out_ready (out_valid rises one cycle after entry)

module alu_ctrl_seq #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_aluop,
  input  logic [5:0]       in_funct,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_cin,
  output logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_cout,
  input  logic             alu_zero,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_cout,
  output logic             out_zero,
  output logic             out_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    CAPT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           r_state;
  logic             r_in_ready;
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic             r_alu_cin;
  logic [3:0]       r_alu_op;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_result;
  logic             r_out_cout;
  logic             r_out_zero;
  logic             r_out_err;

  logic [3:0]       w_op;
  logic             w_cin;
  logic             w_legal;

  // Decode the incoming request to the ALU control word; flag unknown funct codes
  always_comb begin
    w_op    = 4'b0010;
    w_cin   = 1'b0;
    w_legal = 1'b1;
    case (in_aluop)
      2'b00: begin w_op = 4'b0010; w_cin = 1'b0; end
      2'b01: begin w_op = 4'b0110; w_cin = 1'b1; end
      2'b11: begin w_op = 4'b1101; w_cin = 1'b0; end
      default: begin
        case (in_funct)
          6'b100000: begin w_op = 4'b0010; w_cin = 1'b0; end
          6'b100010: begin w_op = 4'b0110; w_cin = 1'b1; end
          6'b100100: begin w_op = 4'b0000; w_cin = 1'b0; end
          6'b100101: begin w_op = 4'b0001; w_cin = 1'b0; end
          6'b100111: begin w_op = 4'b1100; w_cin = 1'b0; end
          6'b101010: begin w_op = 4'b0111; w_cin = 1'b1; end
          default:   begin w_legal = 1'b0; end
        endcase
      end
    endcase
  end

  // Sequencer: accept, issue to the ALU, capture, then hold the response until consumed
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_in_ready   <= 1'b1;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_cin    <= 1'b0;
      r_alu_op     <= 4'b0000;
      r_out_valid  <= 1'b0;
      r_out_result <= '0;
      r_out_cout   <= 1'b0;
      r_out_zero   <= 1'b0;
      r_out_err    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_in_ready <= 1'b0;
            if (w_legal) begin
              // ALU drive registers double as the request latch
              r_alu_a   <= in_a;
              r_alu_b   <= in_b;
              r_alu_cin <= w_cin;
              r_alu_op  <= w_op;
              r_state   <= ISSUE;
            end else begin
              // Illegal funct skips the ALU entirely and leaves alu_* untouched
              r_out_result <= '0;
              r_out_cout   <= 1'b0;
              r_out_zero   <= 1'b0;
              r_out_err    <= 1'b1;
              r_state      <= DONE;
            end
          end
        end
        ISSUE: begin
          r_state <= CAPT;
        end
        CAPT: begin
          r_out_result <= alu_result;
          r_out_cout   <= alu_cout;
          r_out_zero   <= alu_zero;
          r_out_err    <= 1'b0;
          r_state      <= DONE;
        end
        DONE: begin
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_in_ready <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready   = r_in_ready;
  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign alu_cin    = r_alu_cin;
  assign alu_op     = r_alu_op;
  assign out_valid  = r_out_valid;
  assign out_result = r_out_result;
  assign out_cout   = r_out_cout;
  assign out_zero   = r_out_zero;
  assign out_err    = r_out_err;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Bench for alu_ctrl_seq with a behavioural nbit ALU attached.
// Stimulus pushes hand-computed expectations into a queue, and a monitor pops and
// compares them at each response handshake.
module tb_alu_ctrl_seq;
  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   in_aluop;
  logic [5:0]   in_funct;
  logic [W-1:0] in_a, in_b;
  logic [W-1:0] alu_a, alu_b;
  logic         alu_cin;
  logic [3:0]   alu_op;
  logic [W-1:0] alu_result;
  logic         alu_cout, alu_zero;
  logic         out_valid, out_ready;
  logic [W-1:0] out_result;
  logic         out_cout, out_zero, out_err;

  always #5 clk = ~clk;

  alu_ctrl_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_aluop(in_aluop), .in_funct(in_funct), .in_a(in_a), .in_b(in_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_op(alu_op),
    .alu_result(alu_result), .alu_cout(alu_cout), .alu_zero(alu_zero),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_cout(out_cout), .out_zero(out_zero), .out_err(out_err)
  );

  // Behavioural ALU: op[3]=invert a, op[2]=invert b, op[1:0]= and/or/add/slt
  logic [W-1:0] m_a, m_b;
  logic [W:0]   m_sum;
  assign m_a   = alu_op[3] ? ~alu_a : alu_a;
  assign m_b   = alu_op[2] ? ~alu_b : alu_b;
  assign m_sum = {1'b0, m_a} + {1'b0, m_b} + {{W{1'b0}}, alu_cin};
  always_comb begin
    alu_result = '0;
    case (alu_op[1:0])
      2'b00:   alu_result = m_a & m_b;
      2'b01:   alu_result = m_a | m_b;
      2'b10:   alu_result = m_sum[W-1:0];
      default: alu_result = {{(W-1){1'b0}}, m_sum[W-1]};
    endcase
  end
  assign alu_cout = m_sum[W];
  assign alu_zero = (alu_result == '0);

  typedef struct {
    logic [W-1:0] res;
    logic         cout;
    logic         zero;
    logic         err;
    int           acc;
    int           lat;
    int           id;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   nresp = 0;
  int   next_id = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", nm, act, req);
    end
  endtask

  task automatic chki(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  // Monitor: note when out_valid rises, score every handshake against the queue
  logic prev_v = 1'b0;
  int   rise_cyc = 0;
  exp_t e;
  always @(negedge clk) begin
    if (out_valid && !prev_v) rise_cyc = cyc;
    prev_v = out_valid;
    if (out_valid && out_ready) begin
      nresp++;
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_response actual=%h required=none", out_result);
      end else begin
        e = q.pop_front();
        chk ($sformatf("r%0d_result", e.id), out_result, e.res);
        chk1($sformatf("r%0d_cout", e.id), out_cout, e.cout);
        chk1($sformatf("r%0d_zero", e.id), out_zero, e.zero);
        chk1($sformatf("r%0d_err", e.id), out_err, e.err);
        chki($sformatf("r%0d_latency", e.id), rise_cyc - e.acc, e.lat);
      end
    end
  end

  // Issue one request (caller is at posedge+1); returns at posedge+1 of the accept edge
  task automatic send(input logic [1:0] op, input logic [5:0] fn,
                      input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] r, input logic co, input logic z,
                      input logic er, input int lat, input bit push);
    int   n;
    exp_t x;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL in_ready_timeout actual=0 required=1");
      return;
    end
    in_valid = 1'b1;
    in_aluop = op;
    in_funct = fn;
    in_a     = a;
    in_b     = b;
    if (push) begin
      x.res  = r;
      x.cout = co;
      x.zero = z;
      x.err  = er;
      x.acc  = cyc + 1;
      x.lat  = lat;
      x.id   = next_id;
      q.push_back(x);
    end
    next_id++;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while ((q.size() != 0 || !in_ready) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (q.size() != 0 || !in_ready) begin
      checks++;
      failures++;
      $display("FAIL %s_drain_timeout actual=%0d required=0", nm, q.size());
    end
  endtask

  initial begin
    int n;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_aluop = 2'b00; in_funct = 6'd0; in_a = '0; in_b = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk1("rst_in_ready", in_ready, 1'b1);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk ("rst_out_result", out_result, 64'h0);
    chk1("rst_out_err", out_err, 1'b0);
    chk ("rst_alu_op", {60'h0, alu_op}, 64'h0);
    chk ("rst_alu_a", alu_a, 64'h0);
    chk ("rst_alu_b", alu_b, 64'h0);
    chk1("rst_alu_cin", alu_cin, 1'b0);

    // add
    send(2'b00, 6'd0, 64'hff00, 64'h00ee, 64'h000000000000ffee, 1'b0, 1'b0, 1'b0, 3, 1'b1);
    drain("add");
    // sub via funct, zero result
    send(2'b10, 6'b100010, 64'h5, 64'h5, 64'h0, 1'b1, 1'b1, 1'b0, 3, 1'b1);
    chk ("sub_alu_op", {60'h0, alu_op}, 64'h6);
    chk1("sub_alu_cin", alu_cin, 1'b1);
    chk ("sub_alu_a", alu_a, 64'h5);
    drain("sub");
    // slt true then false
    send(2'b10, 6'b101010, 64'h0, 64'h5, 64'h1, 1'b0, 1'b0, 1'b0, 3, 1'b1);
    chk ("slt_alu_op", {60'h0, alu_op}, 64'h7);
    drain("slt1");
    send(2'b10, 6'b101010, 64'hf, 64'h5, 64'h0, 1'b1, 1'b1, 1'b0, 3, 1'b1);
    drain("slt2");
    // and, nor, nand
    send(2'b10, 6'b100100, 64'hffff, 64'habcdef, 64'hcdef, 1'b0, 1'b0, 1'b0, 3, 1'b1);
    drain("and");
    send(2'b10, 6'b100111, 64'h0, 64'h1234567890abcdef, 64'hedcba9876f543210,
         1'b1, 1'b0, 1'b0, 3, 1'b1);
    drain("nor");
    send(2'b11, 6'd0, 64'h0, 64'h1234567890abcdef, 64'hffffffffffffffff,
         1'b1, 1'b0, 1'b0, 3, 1'b1);
    chk ("nand_alu_op", {60'h0, alu_op}, 64'hd);
    drain("nand");
    // illegal funct: fast error response, ALU drive untouched
    send(2'b10, 6'b000000, 64'h77, 64'h88, 64'h0, 1'b0, 1'b0, 1'b1, 1, 1'b1);
    chk ("ill_alu_op", {60'h0, alu_op}, 64'hd);
    chk ("ill_alu_a", alu_a, 64'h0);
    chk ("ill_alu_b", alu_b, 64'h1234567890abcdef);
    drain("ill");

    // backpressure: response must hold while out_ready is low
    out_ready = 1'b0;
    send(2'b00, 6'd0, 64'h1, 64'h2, 64'h3, 1'b0, 1'b0, 1'b0, 3, 1'b1);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk1("bp_valid_seen", out_valid, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk1($sformatf("bp_valid_%0d", i), out_valid, 1'b1);
      chk ($sformatf("bp_result_%0d", i), out_result, 64'h3);
      chk1($sformatf("bp_in_ready_%0d", i), in_ready, 1'b0);
    end
    out_ready = 1'b1;
    drain("bp");

    // reset while in ISSUE: request dropped, no response
    send(2'b00, 6'd0, 64'h10, 64'h20, 64'h30, 1'b0, 1'b0, 1'b0, 3, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk1("rst_issue_out_valid", out_valid, 1'b0);
    chk1("rst_issue_in_ready", in_ready, 1'b1);
    chk ("rst_issue_alu_a", alu_a, 64'h0);
    repeat (6) @(posedge clk);
    #1;
    chk1("rst_issue_quiet", out_valid, 1'b0);

    // recovery with wrap-around carry
    send(2'b00, 6'd0, 64'hffffffffffffffff, 64'h1, 64'h0, 1'b1, 1'b1, 1'b0, 3, 1'b1);
    drain("wrap");
    repeat (2) @(posedge clk);
    #1;
    chki("response_count", nresp, 10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
